// File: rtl/par2ser_pkg.sv
// Shared definitions for the 10-bit parallel-to-serial converter.
// Optional build macro: PAR2SER_PARITY_EN (appends an even-parity bit per frame).
package par2ser_pkg;

  localparam int WIDTH_DEF = 10;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef PAR2SER_PARITY_EN
    SHIFT  = 2'd1,
    PARITY = 2'd2
`else
    SHIFT  = 2'd1
`endif
  } state_t;

endpackage

// File: rtl/par2ser_cnt.sv
// Bit counter for par2ser10: synchronous clear, count enable, terminal count at WIDTH-1.
// Optional build macro: PAR2SER_PARITY_EN (not used in this file).
module par2ser_cnt
  import par2ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  // Wrap at the terminal count so the value never exceeds WIDTH-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/par2ser10.sv
// Parallel-to-serial converter, LSB first, valid/ready on both sides.
// Optional build macro: PAR2SER_PARITY_EN (adds PARITY state and an even-parity bit).
module par2ser10
  import par2ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that transfer occurs.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             in_ready_c, ser_out_c, ser_valid_c, ser_last_c;
`ifdef PAR2SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  par2ser_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (cnt_width(WIDTH))
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    in_ready_c  = 1'b0;
    ser_out_c   = 1'b0;
    ser_valid_c = 1'b0;
    ser_last_c  = 1'b0;
`ifdef PAR2SER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
`ifdef PAR2SER_PARITY_EN
          parity_d = ^in_data;
`endif
        end
      end
      SHIFT: begin
        ser_out_c   = shift_q[0];
        ser_valid_c = 1'b1;
`ifndef PAR2SER_PARITY_EN
        ser_last_c  = cnt_tc;
`endif
        if (ser_ready) begin
          shift_d = shift_q >> 1;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
`ifdef PAR2SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: begin
        ser_out_c   = parity_q;
        ser_valid_c = 1'b1;
        ser_last_c  = 1'b1;
        if (ser_ready) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
`ifdef PAR2SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
`ifdef PAR2SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs are forced quiet while reset is held, even mid-frame.
  assign in_ready  = in_ready_c  & ~rst;
  assign ser_out   = ser_out_c   & ~rst;
  assign ser_valid = ser_valid_c & ~rst;
  assign ser_last  = ser_last_c  & ~rst;

endmodule

// File: tb/tb_par2ser10.sv
// Self-checking bench for par2ser10: frame model, scoreboard queue and monitor.
// Optional build macro: PAR2SER_PARITY_EN (bench expects a parity bit per frame).
module tb_par2ser10;

  localparam int W = 10;
`ifdef PAR2SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_ready;

  par2ser10 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_ready (ser_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];          // {last, bit}
  int         last_accept = 0;
  int         ready_mode = 0;    // 0: always ready, 1: random, 2: manual

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: WIDTH data bits LSB first, then optional even parity; last on final bit.
  function automatic void push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({(i == W - 1) && !PAR, w[i]});
    end
    if (PAR) exp_q.push_back({1'b1, ^w});
  endfunction

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) ser_ready = 1'b1;
      else if (ready_mode == 1) ser_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [W-1:0] w);
    bit got = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (got) begin
      push_frame(w);
      last_accept = cyc;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Cycle-exact frame with ser_ready held high: bit k appears k cycles after accept.
  task automatic directed_frame(input logic [W-1:0] w);
    logic eb;
    send_word(w);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      eb = (k <= W) ? w[k-1] : ^w;
      check("dir_valid", 32'(ser_valid), 32'd1);
      check("dir_bit", 32'(ser_out), 32'(eb));
      check("dir_last", 32'(ser_last), 32'(k == FRAME));
    end
    @(negedge clk);
    check("dir_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev_stall = 1'b0;
    logic [1:0] prev_val = 2'b00;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {29'd0, ser_valid, ser_last, ser_out}, {29'd0, 1'b1, prev_val});
        if (ser_valid && ser_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit", {30'd0, ser_last, ser_out}, 32'hdead);
          end else begin
            e = exp_q.pop_front();
            check("ser_bit", {30'd0, ser_last, ser_out}, {30'd0, e});
          end
        end else if (!ser_valid) begin
          check("quiet_when_invalid", {30'd0, ser_last, ser_out}, 32'd0);
        end
        prev_stall = ser_valid && !ser_ready;
        prev_val   = {ser_last, ser_out};
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b1;

    // Reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", {29'd0, ser_valid, ser_last, ser_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic frames, cycle exact (parity bit when enabled)
    directed_frame(10'h2B5);
    directed_frame(10'h001);
    directed_frame(10'h3FF);

    // Stall three cycles while bit 4 of 10'h2B5 is presented
    ready_mode = 2;
    ser_ready  = 1'b1;
    send_word(10'h2B5);
    repeat (4) @(posedge clk);
    #1;
    ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(ser_valid), 32'd1);
      check("stall_bit4", 32'(ser_out), 32'd1);
    end
    @(posedge clk);
    #1;
    ser_ready = 1'b1;
    wait_idle();
    ready_mode = 0;

    // Word presented while busy is held off until IDLE; back-to-back throughput
    send_word(10'h2B5);
    a1 = last_accept;
    @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    send_word(10'h3FF);
    check("throughput", 32'(last_accept - a1), 32'(FRAME + 1));
    wait_idle();

    // Reset mid-frame at bit 6, then a clean frame
    send_word(10'h2B5);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_outputs", {28'd0, in_ready, ser_valid, ser_last, ser_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {30'd0, in_ready, ser_valid}, 32'd2);
    @(posedge clk);
    #1;
    directed_frame(10'h155);

    // Randomized words, gaps and backpressure
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word(W'($urandom));
    end
    wait_idle();
    ready_mode = 0;

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
